// File: rtl/ssid_memory_arbiter.sv
// ssid_memory_arbiter: round-robin arbiter sharing the SSID hit memory port between the hit-write and
// SSID readout requesters. Optional macro ARB_STATS_EN adds saturating per-requester stall counters.
`default_nettype none

module ssid_memory_arbiter #(
    parameter int SSIDBITS = 8,
    parameter int DATABITS = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wrValid,
    input  logic [SSIDBITS-1:0] wrSSID,
    input  logic [DATABITS-1:0] wrData,
    output logic                wrReady,
    input  logic                rdValid,
    input  logic [SSIDBITS-1:0] rdSSID,
    output logic                rdReady,
    output logic                memValid,
    output logic                memWrite,
    output logic [SSIDBITS-1:0] memSSID,
    output logic [DATABITS-1:0] memData,
`ifdef ARB_STATS_EN
    output logic [15:0]         wrStallCount,
    output logic [15:0]         rdStallCount,
`endif
    input  logic                memReady
);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

    state_t r_state;
    logic   r_last_wr;

    logic w_can_accept;
    logic w_pick_wr;
    logic w_wr_grant;
    logic w_rd_grant;

    // Readies are held low while reset is asserted so nothing is accepted into a register being cleared.
    assign w_can_accept = !reset && ((r_state == IDLE) || memReady);
    assign w_pick_wr    = wrValid && (!rdValid || (wrSSID == rdSSID) || !r_last_wr);
    assign w_wr_grant   = w_can_accept && w_pick_wr;
    assign w_rd_grant   = w_can_accept && rdValid && !w_pick_wr;

    assign wrReady = w_wr_grant;
    assign rdReady = w_rd_grant;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_last_wr <= 1'b0;
            memValid  <= 1'b0;
            memWrite  <= 1'b0;
            memSSID   <= '0;
            memData   <= '0;
        end else if (w_wr_grant || w_rd_grant) begin
            r_state   <= ISSUE;
            r_last_wr <= w_wr_grant;
            memValid  <= 1'b1;
            memWrite  <= w_wr_grant;
            memSSID   <= w_wr_grant ? wrSSID : rdSSID;
            memData   <= w_wr_grant ? wrData : '0;
        end else if (r_state == ISSUE && memReady) begin
            r_state   <= IDLE;
            memValid  <= 1'b0;
        end
    end

`ifdef ARB_STATS_EN
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrStallCount <= '0;
            rdStallCount <= '0;
        end else begin
            if (wrValid && !w_wr_grant && wrStallCount != 16'hFFFF)
                wrStallCount <= wrStallCount + 16'd1;
            if (rdValid && !w_rd_grant && rdStallCount != 16'hFFFF)
                rdStallCount <= rdStallCount + 16'd1;
        end
    end
`endif

endmodule

`default_nettype wire

// File: tb/tb_ssid_memory_arbiter.sv
// tb_ssid_memory_arbiter: directed stimulus with a transaction scoreboard for ssid_memory_arbiter.
`default_nettype none

module tb_ssid_memory_arbiter;

    logic       clock = 1'b0;
    logic       reset;
    logic       wrValid, rdValid, memReady;
    logic [7:0] wrSSID, rdSSID, wrData;
    logic       wrReady, rdReady, memValid, memWrite;
    logic [7:0] memSSID, memData;
`ifdef ARB_STATS_EN
    logic [15:0] wrStallCount, rdStallCount;
`endif

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic       w;
        logic [7:0] s;
        logic [7:0] d;
    } txn_t;

    txn_t sb[$];

    ssid_memory_arbiter #(.SSIDBITS(8), .DATABITS(8)) dut (
        .clock    (clock),
        .reset    (reset),
        .wrValid  (wrValid),
        .wrSSID   (wrSSID),
        .wrData   (wrData),
        .wrReady  (wrReady),
        .rdValid  (rdValid),
        .rdSSID   (rdSSID),
        .rdReady  (rdReady),
        .memValid (memValid),
        .memWrite (memWrite),
        .memSSID  (memSSID),
        .memData  (memData),
`ifdef ARB_STATS_EN
        .wrStallCount (wrStallCount),
        .rdStallCount (rdStallCount),
`endif
        .memReady (memReady)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_edge();
        @(posedge clock);
        #1;
    endtask

    task automatic sample();
        @(negedge clock);
    endtask

    // A handshake seen at the negedge completes at the following posedge.
    always @(negedge clock) begin
        if (reset === 1'b0 && memValid === 1'b1 && memReady === 1'b1) begin
            chk("sb_nonempty", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                txn_t e;
                e = sb.pop_front();
                chk("sb_txn", {15'd0, memWrite, memSSID, memData}, {15'd0, e});
            end
        end
    end

    initial begin
        logic [7:0] ssids [3];
        ssids[0] = 8'h00; ssids[1] = 8'h33; ssids[2] = 8'hCF;
        reset = 1'b1; wrValid = 0; rdValid = 0; memReady = 0;
        wrSSID = 0; rdSSID = 0; wrData = 0;

        sample();
        chk("rst_memValid", {31'd0, memValid}, 32'd0);
        chk("rst_memWrite", {31'd0, memWrite}, 32'd0);
        chk("rst_memSSID",  {24'd0, memSSID},  32'd0);
        chk("rst_memData",  {24'd0, memData},  32'd0);
        chk("rst_readies",  {30'd0, wrReady, rdReady}, 32'd0);

        // Read-only stream
        drive_edge(); reset = 1'b0; memReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_edge(); rdValid = 1'b1; rdSSID = ssids[i];
            sample();
            chk("rdonly_rdReady", {31'd0, rdReady}, 32'd1);
            chk("rdonly_wrReady", {31'd0, wrReady}, 32'd0);
            sb.push_back('{1'b0, ssids[i], 8'h00});
        end
        drive_edge(); rdValid = 1'b0;
        sample();
        chk("rdonly_last_rdReady", {31'd0, rdReady}, 32'd0);
        drive_edge(); sample();
        chk("rdonly_idle", {31'd0, memValid}, 32'd0);

        // Contention: lastGrant is READ, so W,R,W,R
        for (int i = 0; i < 4; i++) begin
            drive_edge(); wrValid = 1; rdValid = 1; wrSSID = 8'h12; rdSSID = 8'h34; wrData = 8'hA5;
            sample();
            chk("cont_wrReady", {31'd0, wrReady}, (i % 2 == 0) ? 32'd1 : 32'd0);
            chk("cont_rdReady", {31'd0, rdReady}, (i % 2 == 0) ? 32'd0 : 32'd1);
            if (i % 2 == 0) sb.push_back('{1'b1, 8'h12, 8'hA5});
            else            sb.push_back('{1'b0, 8'h34, 8'h00});
        end
        drive_edge(); wrValid = 0; rdValid = 0;

        // Same SSID: prime lastGrant=WRITE, then contest on FF
        wrValid = 1; wrSSID = 8'hFF; wrData = 8'h5A;
        sample();
        chk("same_prime_w", {31'd0, wrReady}, 32'd1);
        sb.push_back('{1'b1, 8'hFF, 8'h5A});
        drive_edge(); rdValid = 1; rdSSID = 8'hFF; wrData = 8'h6B;
        sample();
        chk("same_ssid_w", {30'd0, wrReady, rdReady}, 32'd2);
        sb.push_back('{1'b1, 8'hFF, 8'h6B});
        drive_edge(); wrSSID = 8'h01; wrData = 8'h7C;
        sample();
        chk("same_next_r", {30'd0, wrReady, rdReady}, 32'd1);
        sb.push_back('{1'b0, 8'hFF, 8'h00});
        drive_edge(); rdValid = 0;
        sample();
        chk("same_tail_w", {30'd0, wrReady, rdReady}, 32'd2);
        sb.push_back('{1'b1, 8'h01, 8'h7C});
        drive_edge(); wrValid = 0;
        drive_edge(); sample();
        chk("same_idle", {31'd0, memValid}, 32'd0);

        // Backpressure
        drive_edge(); memReady = 0; wrValid = 1; wrSSID = 8'h77; wrData = 8'hC3;
        sample();
        chk("bp_first_w", {31'd0, wrReady}, 32'd1);
        sb.push_back('{1'b1, 8'h77, 8'hC3});
        drive_edge(); wrSSID = 8'h88; wrData = 8'h3C;
        for (int k = 0; k < 5; k++) begin
            sample();
            chk("bp_readies", {30'd0, wrReady, rdReady}, 32'd0);
            chk("bp_hold", {14'd0, memValid, memWrite, memSSID, memData}, {14'd0, 1'b1, 1'b1, 8'h77, 8'hC3});
            drive_edge();
        end
        memReady = 1;
        sample();
        chk("bp_release_w", {31'd0, wrReady}, 32'd1);
        sb.push_back('{1'b1, 8'h88, 8'h3C});
        drive_edge(); wrValid = 0;
        drive_edge(); sample();
        chk("bp_idle", {31'd0, memValid}, 32'd0);

        // Reset in the middle of an outstanding request
        drive_edge(); memReady = 0; wrValid = 1; wrSSID = 8'hAB; wrData = 8'hCD;
        rdValid = 1; rdSSID = 8'h55;
        sample();
        chk("mid_grant_r", {30'd0, wrReady, rdReady}, 32'd1);
        sb.push_back('{1'b0, 8'h55, 8'h00});
        drive_edge(); sample();
        chk("mid_issue", {31'd0, memValid}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_memValid", {31'd0, memValid}, 32'd0);
        chk("mid_rst_readies", {30'd0, wrReady, rdReady}, 32'd0);
        chk("mid_rst_memSSID", {24'd0, memSSID}, 32'd0);
        sb.delete();
        drive_edge(); drive_edge(); reset = 1'b0; memReady = 1;

        // lastGrant restored to READ: contested grant goes to WRITE
        sample();
        chk("post_rst_w", {30'd0, wrReady, rdReady}, 32'd2);
        sb.push_back('{1'b1, 8'hAB, 8'hCD});
        drive_edge(); wrValid = 0;
        sample();
        chk("post_rst_r", {30'd0, wrReady, rdReady}, 32'd1);
        sb.push_back('{1'b0, 8'h55, 8'h00});
        drive_edge(); rdValid = 0;
        drive_edge(); sample();
        chk("sb_drained", sb.size(), 32'd0);

`ifdef ARB_STATS_EN
        drive_edge(); reset = 1'b1;
        drive_edge(); reset = 1'b0; memReady = 0; rdValid = 1; rdSSID = 8'h42;
        repeat (70000) @(posedge clock);
        sample();
        chk("stats_rd_sat", {16'd0, rdStallCount}, 32'h0000FFFF);
        chk("stats_wr_zero", {16'd0, wrStallCount}, 32'd0);
        drive_edge(); reset = 1'b1; rdValid = 0; sb.delete();
        drive_edge(); reset = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
